addsub_share_ctrl: RTL and testbench

Sequencing controller that shares one n-bit adder-subtracter datapath between two requesters. Each requester presents an operand pair and an add/subtract select over a valid/ready handshake. A round-robin arbiter grants one request at a time, and the controller drives the shared adder-subtracter from registered operands. The result is returned on a single response channel tagged with the requester ID.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_share_ctrl_if.sv | 47 ++++
 rtl/addsub_unit.sv | 16 +
 rtl/rr_arb2.sv | 34 +++
 rtl/addsub_share_ctrl.sv | 111 +++++++++++
 tb/tb_addsub_share_ctrl.sv | 284 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester adder-subtracter controller.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0   = 1'b0;
    localparam logic REQ1   = 1'b1;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_share_ctrl_if.sv
// Request/response bundle between two requesters, a consumer and the controller.
// rsp_ovf exists only when ADDSUB_OVF_FLAG_EN is defined.
interface addsub_share_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_sub;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_sum;
    logic         rsp_cout;
`ifdef ADDSUB_OVF_FLAG_EN
    logic         rsp_ovf;
`endif

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef ADDSUB_OVF_FLAG_EN
        , input rsp_ovf
`endif
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef ADDSUB_OVF_FLAG_EN
        , output rsp_ovf
`endif
    );

endinterface

// File: rtl/addsub_unit.sv
// N-bit adder-subtracter: sum = a + (b ^ {N{sub}}) + sub, cout is bit N.
module addsub_unit #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin
        {cout, sum} = (N+1)'(a) + (N+1)'(b ^ {N{sub}}) + (N+1)'(sub);
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves past the winner on accept.
module rr_arb2
    import addsub_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic ptr;

    always_comb begin
        grant_c = 2'b00;
        if (valid0 && valid1) begin
            grant_c = (ptr == REQ1) ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant_c = 2'b01;
        end else if (valid1) begin
            grant_c = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ0;
        end else if (accept) begin
            ptr <= grant_c[1] ? REQ0 : REQ1;
        end
    end

endmodule

// File: rtl/addsub_share_ctrl.sv
// Shares one adder-subtracter between two requesters; IDLE -> CALC -> RESP per operation.
// Optional signed overflow flag enabled by ADDSUB_OVF_FLAG_EN.
module addsub_share_ctrl
    import addsub_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic               clk,
    input  logic               rst,
    addsub_share_ctrl_if.slave bus
);

    state_t       state;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         sub_q;
    logic         id_q;
    logic [1:0]   grant_c;
    logic         accept_c;
    logic [N-1:0] sum_c;
    logic         cout_c;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [N-1:0] rsp_sum_q;
    logic         rsp_cout_q;

    assign bus.req0_ready = (state == IDLE) & grant_c[0];
    assign bus.req1_ready = (state == IDLE) & grant_c[1];
    assign accept_c       = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid0  (bus.req0_valid),
        .valid1  (bus.req1_valid),
        .accept  (accept_c),
        .grant_c (grant_c)
    );

    addsub_unit #(.N(N)) u_addsub (
        .a    (a_q),
        .b    (b_q),
        .sub  (sub_q),
        .sum  (sum_c),
        .cout (cout_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= OP_ADD;
            id_q        <= REQ0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        a_q   <= grant_c[1] ? bus.req1_a   : bus.req0_a;
                        b_q   <= grant_c[1] ? bus.req1_b   : bus.req0_b;
                        sub_q <= grant_c[1] ? bus.req1_sub : bus.req0_sub;
                        id_q  <= grant_c[1] ? REQ1 : REQ0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum_q   <= sum_c;
                    rsp_cout_q  <= cout_c;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;

`ifdef ADDSUB_OVF_FLAG_EN
    // Overflow when both effective operands share a sign that the sum does not.
    logic ovf_c;
    logic rsp_ovf_q;

    assign ovf_c = (a_q[N-1] == (b_q[N-1] ^ sub_q)) & (sum_c[N-1] != a_q[N-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ovf_q <= 1'b0;
        end else if (state == CALC) begin
            rsp_ovf_q <= ovf_c;
        end
    end

    assign bus.rsp_ovf = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl; drives at posedge+2, samples before the next edge.
module tb_addsub_share_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    addsub_share_ctrl_if #(.N(8)) bus ();

    addsub_share_ctrl #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_a     = 8'h00;
        bus.req0_b     = 8'h00;
        bus.req0_sub   = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = 8'h00;
        bus.req1_b     = 8'h00;
        bus.req1_sub   = 1'b0;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
        end
        n_cmp++;
        if (bus.rsp_sum !== 8'h00 || bus.rsp_id !== 1'b0 || bus.rsp_cout !== 1'b0) begin
            n_err++; $display("FAIL reset_rsp_regs: got sum=%h id=%b cout=%b expected 00/0/0",
                              bus.rsp_sum, bus.rsp_id, bus.rsp_cout);
        end
        rst = 1'b0;
        next_cycle();
        n_cmp++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_no_ready: got r0=%b r1=%b expected 0/0",
                              bus.req0_ready, bus.req1_ready);
        end
    endtask

    task automatic test_add();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 8'h05;
        bus.req0_b     = 8'h03;
        bus.req0_sub   = 1'b0;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_err++; $display("FAIL add_ready: got r0=%b r1=%b expected 1/0",
                              bus.req0_ready, bus.req1_ready);
        end
        next_cycle();
        bus.req0_valid = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL add_latency_t1: got rsp_valid=%b expected 0", bus.rsp_valid);
        end
        next_cycle();
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_sum !== 8'h08 || bus.rsp_cout !== 1'b0) begin
            n_err++; $display("FAIL add_rsp: got v=%b id=%b sum=%h cout=%b expected 1/0/08/0",
                              bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
        end
`ifdef ADDSUB_OVF_FLAG_EN
        n_cmp++;
        if (bus.rsp_ovf !== 1'b0) begin
            n_err++; $display("FAIL add_ovf: got %b expected 0", bus.rsp_ovf);
        end
`endif
        next_cycle();
        n_cmp++;
        if (bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL add_consumed: got rsp_valid=%b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_sub();
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        logic [7:0] ts [2];
        logic       tc [2];
        ta[0] = 8'h05; tb[0] = 8'h03; ts[0] = 8'h02; tc[0] = 1'b1;
        ta[1] = 8'h03; tb[1] = 8'h05; ts[1] = 8'hFE; tc[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = ta[i];
            bus.req1_b     = tb[i];
            bus.req1_sub   = 1'b1;
            #1;
            n_cmp++;
            if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
                n_err++; $display("FAIL sub%0d_ready: got r0=%b r1=%b expected 0/1",
                                  i, bus.req0_ready, bus.req1_ready);
            end
            next_cycle();
            bus.req1_valid = 1'b0;
            next_cycle();
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_sum !== ts[i] || bus.rsp_cout !== tc[i]) begin
                n_err++; $display("FAIL sub%0d_rsp: got v=%b id=%b sum=%h cout=%b expected 1/1/%h/%b",
                                  i, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, ts[i], tc[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic e_r0 [7];
        logic e_r1 [7];
        logic e_rv [7];
        logic e_id [7];
        logic [7:0] e_sum [7];
        e_r0 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        e_r1 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e_rv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        e_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e_sum = '{8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h1E, 8'h00};
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h10; bus.req0_b = 8'h01; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h20; bus.req1_b = 8'h02; bus.req1_sub = 1'b1;
        #1;
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (bus.req0_ready !== e_r0[c] || bus.req1_ready !== e_r1[c] || bus.rsp_valid !== e_rv[c]) begin
                n_err++; $display("FAIL b2b_c%0d_hs: got r0=%b r1=%b v=%b expected %b/%b/%b",
                                  c, bus.req0_ready, bus.req1_ready, bus.rsp_valid, e_r0[c], e_r1[c], e_rv[c]);
            end
            if (e_rv[c]) begin
                n_cmp++;
                if (bus.rsp_id !== e_id[c] || bus.rsp_sum !== e_sum[c]) begin
                    n_err++; $display("FAIL b2b_c%0d_rsp: got id=%b sum=%h expected %b/%h",
                                      c, bus.rsp_id, bus.rsp_sum, e_id[c], e_sum[c]);
                end
            end
            if (c == 6) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end else begin
                @(posedge clk);
                #3;
            end
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        bus.rsp_ready  = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h7F; bus.req1_b = 8'h01; bus.req1_sub = 1'b0;
        next_cycle();
        bus.req1_valid = 1'b0;
        next_cycle();
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h01; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_sum !== 8'h80 || bus.rsp_cout !== 1'b0) begin
                n_err++; $display("FAIL bp_c%0d_hold: got v=%b id=%b sum=%h cout=%b expected 1/1/80/0",
                                  c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
            end
            n_cmp++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_c%0d_ready: got r0=%b r1=%b expected 0/0",
                                  c, bus.req0_ready, bus.req1_ready);
            end
`ifdef ADDSUB_OVF_FLAG_EN
            n_cmp++;
            if (bus.rsp_ovf !== 1'b1) begin
                n_err++; $display("FAIL bp_c%0d_ovf: got %b expected 1", c, bus.rsp_ovf);
            end
`endif
            next_cycle();
        end
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        next_cycle();
        bus.req0_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got v=%b r0=%b expected 0/1", bus.rsp_valid, bus.req0_ready);
        end
        bus.req0_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.req0_valid = 1'b1; bus.req0_a = 8'h05; bus.req0_b = 8'h03; bus.req0_sub = 1'b0;
        next_cycle();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 8'h00) begin
            n_err++; $display("FAIL rstmid_rsp: got v=%b sum=%h expected 0/00", bus.rsp_valid, bus.rsp_sum);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ptr: got r0=%b r1=%b expected 1/0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            n_cmp++;
            if (bus.rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL rstmid_stale_c%0d: got rsp_valid=%b expected 0", c, bus.rsp_valid);
            end
        end
    endtask

`ifdef ADDSUB_OVF_FLAG_EN
    task automatic test_ovf();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tsb [3];
        logic [7:0] ts [3];
        logic       tv [3];
        ta[0] = 8'h7F; tb[0] = 8'h01; tsb[0] = 1'b0; ts[0] = 8'h80; tv[0] = 1'b1;
        ta[1] = 8'h80; tb[1] = 8'h01; tsb[1] = 1'b1; ts[1] = 8'h7F; tv[1] = 1'b1;
        ta[2] = 8'h05; tb[2] = 8'h03; tsb[2] = 1'b0; ts[2] = 8'h08; tv[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = ta[i];
            bus.req0_b     = tb[i];
            bus.req0_sub   = tsb[i];
            next_cycle();
            bus.req0_valid = 1'b0;
            next_cycle();
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== ts[i] || bus.rsp_ovf !== tv[i]) begin
                n_err++; $display("FAIL ovf%0d: got v=%b sum=%h ovf=%b expected 1/%h/%b",
                                  i, bus.rsp_valid, bus.rsp_sum, bus.rsp_ovf, ts[i], tv[i]);
            end
            next_cycle();
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef ADDSUB_OVF_FLAG_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
